// File: rtl/keypad_controller_pkg.sv
// Shared keypad types and the KEYCNT interrupt-condition helper.
`include "gba_mmio_defines.vh"

package keypad_controller_pkg;

   localparam int NUM_KEYS = 10;

   typedef logic [NUM_KEYS-1:0] keys_t;

   // AND mode with an empty mask is defined as never true.
   function automatic logic keycnt_cond(input keys_t pressed, input keys_t mask,
                                        input logic irq_en, input logic and_mode);
      logic hit_any;
      logic hit_all;
      hit_any = |(pressed & mask);
      hit_all = (mask != '0) && ((pressed & mask) == mask);
      return irq_en && (and_mode ? hit_all : hit_any);
   endfunction

endpackage

// File: rtl/gba_mmio_defines.vh
// GBA MMIO bit positions for the keypad block: KEYINPUT order, SNES pad order, KEYCNT fields.
`ifndef GBA_MMIO_DEFINES_VH
`define GBA_MMIO_DEFINES_VH

`define KEYCNT_IDX       9'h099

`define KEYINPUT_A       0
`define KEYINPUT_B       1
`define KEYINPUT_SELECT  2
`define KEYINPUT_START   3
`define KEYINPUT_RIGHT   4
`define KEYINPUT_LEFT    5
`define KEYINPUT_UP      6
`define KEYINPUT_DOWN    7
`define KEYINPUT_R       8
`define KEYINPUT_L       9

`define SNES_B           0
`define SNES_Y           1
`define SNES_SELECT      2
`define SNES_START       3
`define SNES_UP          4
`define SNES_DOWN        5
`define SNES_LEFT        6
`define SNES_RIGHT       7
`define SNES_A           8
`define SNES_X           9
`define SNES_L           10
`define SNES_R           11

`define KEYCNT_MASK_MSB  9
`define KEYCNT_IRQ_EN    14
`define KEYCNT_COND      15

`endif

// File: rtl/keypad_debounce.sv
// Debounces the remapped key vector; a held change commits DEBOUNCE_CYCLES+1 cycles after it reaches keys_i.
// Output is active-low (KEYINPUT polarity); no backpressure.
module keypad_debounce
   import keypad_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4096
) (
   input  logic  clock,
   input  logic  reset,
   input  keys_t keys_i,
   output keys_t keyinput_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   keys_t         cand_q, cand_d;
   keys_t         keyinput_q, keyinput_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter saturates at CNT_MAX and keeps re-committing the same value until the next change.
   always_comb begin
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      keyinput_d = keyinput_q;
      if (keys_i != cand_q) begin
         cand_d = keys_i;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         keyinput_d = ~cand_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cand_q     <= '0;
         cnt_q      <= '0;
         keyinput_q <= '1;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         keyinput_q <= keyinput_d;
      end
   end

   assign keyinput_o = keyinput_q;

endmodule

// File: rtl/keypad_controller.sv
// GBA keypad: SNES pad -> synchronizer -> remap -> KEYINPUT (debounced when KEYPAD_DEBOUNCE_EN is defined,
// else 3-cycle latency), plus KEYCNT edge-triggered interrupt pulse. No backpressure.
`include "gba_mmio_defines.vh"

module keypad_controller
   import keypad_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] buttons,
   input  logic [15:0] keycnt,
   output logic [15:0] keyinput,
   output logic        keypad_irq
);

   logic [15:0] sync1_q, sync2_q;
   keys_t       mapped;
   keys_t       keys_n;
   keys_t       pressed;
   logic        cond_d, cond_q;
   logic        unused_bits;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= buttons;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      mapped                   = '0;
      mapped[`KEYINPUT_A]      = sync2_q[`SNES_A];
      mapped[`KEYINPUT_B]      = sync2_q[`SNES_B];
      mapped[`KEYINPUT_SELECT] = sync2_q[`SNES_SELECT];
      mapped[`KEYINPUT_START]  = sync2_q[`SNES_START];
      mapped[`KEYINPUT_RIGHT]  = sync2_q[`SNES_RIGHT];
      mapped[`KEYINPUT_LEFT]   = sync2_q[`SNES_LEFT];
      mapped[`KEYINPUT_UP]     = sync2_q[`SNES_UP];
      mapped[`KEYINPUT_DOWN]   = sync2_q[`SNES_DOWN];
      mapped[`KEYINPUT_R]      = sync2_q[`SNES_R];
      mapped[`KEYINPUT_L]      = sync2_q[`SNES_L];
   end

`ifdef KEYPAD_DEBOUNCE_EN
   keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .keys_i     (mapped),
      .keyinput_o (keys_n)
   );
`else
   keys_t keyinput_q;
   logic  unused_dc;

   always_ff @(posedge clock) begin
      if (reset) keyinput_q <= '1;
      else       keyinput_q <= ~mapped;
   end

   assign keys_n    = keyinput_q;
   assign unused_dc = (DEBOUNCE_CYCLES > 0);
`endif

   assign keyinput = {6'b0, keys_n};
   assign pressed  = ~keys_n;

   assign cond_d = keycnt_cond(pressed, keycnt[`KEYCNT_MASK_MSB:0],
                               keycnt[`KEYCNT_IRQ_EN], keycnt[`KEYCNT_COND]);

   always_ff @(posedge clock) begin
      if (reset) cond_q <= 1'b0;
      else       cond_q <= cond_d;
   end

   // Rising edge of the condition, visible in the same cycle keyinput commits.
   assign keypad_irq = cond_d & ~cond_q & ~reset;

   assign unused_bits = ^{sync2_q[`SNES_Y], sync2_q[`SNES_X], sync2_q[15:12], keycnt[13:10]};

endmodule

// File: tb/tb_keypad_controller.sv
// Directed bench for keypad_controller at DEBOUNCE_CYCLES = 8; latency expectations track KEYPAD_DEBOUNCE_EN.
module tb_keypad_controller;

   localparam int DC = 8;
`ifdef KEYPAD_DEBOUNCE_EN
   localparam int LAT  = DC + 3;
   localparam int PEND = DC + 1;
`else
   localparam int LAT  = 3;
   localparam int PEND = 1;
`endif

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic [15:0] buttons = '0;
   logic [15:0] keycnt  = '0;
   logic [15:0] keyinput;
   logic        keypad_irq;

   int n_chk    = 0;
   int n_fail   = 0;
   int irq_seen = 0;

   logic [15:0] map_exp [16];

   keypad_controller #(
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .buttons    (buttons),
      .keycnt     (keycnt),
      .keyinput   (keyinput),
      .keypad_irq (keypad_irq)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (keypad_irq === 1'b1) irq_seen++;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Called just after a posedge at which the change was applied.
   task automatic expect_commit(input string tag, input logic [15:0] old_v,
                                input logic [15:0] new_v, input logic exp_irq);
      for (int j = 0; j <= LAT + 1; j++) begin
         @(negedge clock);
         chk({tag, ".ki"}, keyinput, (j < LAT) ? old_v : new_v);
         chk({tag, ".irq"}, {15'b0, keypad_irq}, {15'b0, (j == LAT) ? exp_irq : 1'b0});
      end
      tick();
   endtask

   task automatic press(input string tag, input logic [15:0] btn, input logic [15:0] old_v,
                        input logic [15:0] new_v, input logic exp_irq);
      buttons = btn;
      expect_commit(tag, old_v, new_v, exp_irq);
   endtask

   task automatic glitch(input int len);
      buttons = 16'h0001;
      for (int c = 0; c < len + LAT + 3; c++) begin
         @(negedge clock);
         chk($sformatf("glitch%0d", len), keyinput, 16'h03FF);
         tick();
         if (c == len - 1) buttons = '0;
      end
   endtask

   initial begin
      logic [15:0] prev;
      int          p;
      logic        v;

      map_exp = '{16'h03FD, 16'h03FF, 16'h03FB, 16'h03F7, 16'h03BF, 16'h037F, 16'h03DF, 16'h03EF,
                  16'h03FE, 16'h03FF, 16'h01FF, 16'h02FF, 16'h03FF, 16'h03FF, 16'h03FF, 16'h03FF};

      repeat (3) @(posedge clock);
      #1;
      chk("reset.ki", keyinput, 16'h03FF);
      chk("reset.irq", {15'b0, keypad_irq}, 16'h0000);
      reset = 1'b0;
      repeat (LAT + 2) tick();
      chk("idle.ki", keyinput, 16'h03FF);

      press("pressA", 16'h0100, 16'h03FF, 16'h03FE, 1'b0);
      press("relA", 16'h0000, 16'h03FE, 16'h03FF, 1'b0);

      prev = 16'h03FF;
      for (int i = 0; i < 16; i++) begin
         press($sformatf("map%0d", i), 16'(1) << i, prev, map_exp[i], 1'b0);
         prev = map_exp[i];
      end
      press("mapRel", 16'h0000, prev, 16'h03FF, 1'b0);

`ifdef KEYPAD_DEBOUNCE_EN
      glitch(5);
      glitch(DC - 1);
`else
      for (int c = 0; c < 24; c++) begin
         buttons[8] = c[0];
         @(negedge clock);
         p = c - 3;
         v = (p >= 0) ? p[0] : 1'b0;
         chk($sformatf("toggle%0d", c), {15'b0, keyinput[0]}, {15'b0, ~v});
         tick();
      end
      buttons = '0;
      repeat (LAT + 2) tick();
`endif

      // OR mode on A|B
      keycnt = 16'h4003;
      tick();
      press("orB", 16'h0001, 16'h03FF, 16'h03FD, 1'b1);
      irq_seen = 0;
      repeat (100) tick();
      chk("or.hold", 16'(irq_seen), 16'd0);
      press("orRel", 16'h0000, 16'h03FD, 16'h03FF, 1'b0);

      // AND mode on A&B: only the second key fires
      keycnt = 16'hC003;
      tick();
      press("andA", 16'h0100, 16'h03FF, 16'h03FE, 1'b0);
      repeat (20 - (LAT + 2)) tick();
      press("andB", 16'h0101, 16'h03FE, 16'h03FC, 1'b1);
      irq_seen = 0;
      repeat (10) tick();
      chk("and.hold", 16'(irq_seen), 16'd0);
      press("andRel", 16'h0000, 16'h03FC, 16'h03FF, 1'b0);

      keycnt = 16'hC000;
      press("andEmpty", 16'h0FFF, 16'h03FF, 16'h0000, 1'b0);
      irq_seen = 0;
      repeat (30) tick();
      chk("andEmpty.hold", 16'(irq_seen), 16'd0);

      // KEYCNT writes while keys are held
      keycnt = 16'h4001;
      @(negedge clock);
      chk("wr1.irq", {15'b0, keypad_irq}, 16'h0001);
      @(negedge clock);
      chk("wr1.after", {15'b0, keypad_irq}, 16'h0000);
      tick();
      keycnt = 16'h0000;
      tick();
      keycnt = 16'hC3FF;
      @(negedge clock);
      chk("wr2.irq", {15'b0, keypad_irq}, 16'h0001);
      @(negedge clock);
      chk("wr2.after", {15'b0, keypad_irq}, 16'h0000);
      tick();
      keycnt = 16'h0000;
      tick();
      press("relAll", 16'h0000, 16'h0000, 16'h03FF, 1'b0);

      // Reset while a press is still in flight
      buttons = 16'h0100;
      repeat (PEND) tick();
      chk("rst.pending", keyinput, 16'h03FF);
      reset = 1'b1;
      tick();
      chk("rst.ki", keyinput, 16'h03FF);
      chk("rst.irq", {15'b0, keypad_irq}, 16'h0000);
      tick();
      reset = 1'b0;
      expect_commit("rst.rel", 16'h03FF, 16'h03FE, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_controller.md
KEYPAD_CONTROLLER -- requirements
Module: keypad_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4096, meaning the number of consecutive stable cycles required to commit a key change (min 1).
REQ-002 SHALL have port clock, input, 1 bit: the 16.776 MHz GBA clock; the sole clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have port buttons, input, 16 bits: SNES controller state, 1 = pressed, asynchronous to clock; bits 0..11 = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
REQ-005 SHALL have port keycnt, input, 16 bits: KEYCNT register; [9:0] key mask, [14] IRQ enable, [15] condition (0 = OR, 1 = AND).
REQ-006 SHALL have port keyinput, output, 16 bits: GBA KEYINPUT, active-low; [0] A, [1] B, [2] Select, [3] Start, [4] Right, [5] Left, [6] Up, [7] Down, [8] R, [9] L; [15:10] = 0.
REQ-007 SHALL have port keypad_irq, output, 1 bit: one-cycle interrupt request pulse to the interrupt controller keypad input.

Function
REQ-008 SHALL pass buttons through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-009 SHALL remap sync2 to the GBA key order of REQ-006; SNES Y and X and buttons[15:12] SHALL be ignored.
REQ-010 With debounce enabled, SHALL hold a 10-bit candidate and a stable counter; when the mapped value differs from the candidate, the block SHALL load the candidate and clear the counter.
REQ-011 When the counter reaches DEBOUNCE_CYCLES-1 with the mapped value equal to the candidate, the block SHALL commit the inverted candidate to keyinput[9:0] and saturate the counter until the next change.
REQ-012 A button change held stable SHALL appear on keyinput exactly DEBOUNCE_CYCLES+3 cycles after it is applied at buttons.
REQ-013 A change lasting fewer than DEBOUNCE_CYCLES cycles at sync2 SHALL never reach keyinput.
REQ-014 Define pressed = ~keyinput[9:0] and m = keycnt[9:0]; the condition SHALL be keycnt[14] AND (keycnt[15] ? (m != 0 AND (pressed & m) == m) : |(pressed & m)).
REQ-015 SHALL register the condition into cond_q every cycle and assert keypad_irq for exactly one cycle when the condition is 1 and cond_q is 0.
REQ-016 A keycnt write that makes the condition true while keys are already held SHALL produce one pulse.
REQ-017 Holding keys while the condition stays true SHALL produce no further pulses; the condition must first drop for one cycle.
REQ-018 In AND mode with m = 0 the block SHALL never assert keypad_irq.

Reset
REQ-019 On reset, the block SHALL clear sync1, sync2, the candidate, the counter and cond_q to 0, and set keyinput = 16'h03FF and keypad_irq = 0.
REQ-020 Reset mid-debounce SHALL discard the pending change; keys still held after reset SHALL be debounced afresh per REQ-012.

Configuration
REQ-021 Macro KEYPAD_DEBOUNCE_EN defined: debounce per REQ-010 to REQ-013.
REQ-022 Macro KEYPAD_DEBOUNCE_EN undefined: no candidate or counter; keyinput[9:0] SHALL register the inverted mapped sync2 every cycle (latency 3 cycles), and DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-023 KEYINPUT bit indices, the SNES bit indices, the KEYCNT field positions and KEYCNT_IDX SHALL live in gba_mmio_defines.vh.
REQ-024 The candidate/counter logic SHALL be one sub-module, keypad_debounce, instantiated only under KEYPAD_DEBOUNCE_EN.

Verification (DEBOUNCE_CYCLES = 8 for the bench)
REQ-025 Reset, then buttons = 16'h0100 (A) held -> keyinput = 16'h03FE exactly 11 cycles later, 16'h03FF before that.
REQ-026 Press buttons = 16'h0001 (B) for 5 cycles, then release -> keyinput stays 16'h03FF throughout.
REQ-027 keycnt = 16'h4003 (OR, A|B), press B -> keypad_irq high for exactly 1 cycle, coincident with the commit of keyinput = 16'h03FD; held 100 cycles -> no second pulse.
REQ-028 keycnt = 16'hC003 (AND), press A, then B 20 cycles later -> single pulse only after B commits; keycnt = 16'hC000 with all keys pressed -> no pulse.
REQ-029 Pulse reset during a pending press (cycle 6 of 8) with buttons held -> keyinput = 16'h03FF during reset, press commits 11 cycles after reset deasserts.
REQ-030 Build without KEYPAD_DEBOUNCE_EN, toggle buttons[8] each cycle -> keyinput[0] follows inverted with 3-cycle latency.
